rptr_empty_lvl: RTL
===================

Name: rptr_empty_lvl

Overview:
Read-domain pointer and status block for the asynchronous FIFO, and the successor to the basic read-pointer/empty generator. It keeps the binary and Gray read pointers and produces the RAM read address and a registered empty flag. It also decodes the synchronised write pointer to add a fill-level count, a programmable almost-empty flag and a sticky underflow flag. It sits in the rclk domain, between the 2-flop wptr synchroniser and the dual-port RAM read port.

Parameters:
address_width, 4, RAM address bits; FIFO depth DEPTH = 2**address_width
aempty_thresh, 2, raempty asserts when level <= this value; legal range 0..DEPTH-1

Ports:
rclk  input  1  read-domain clock; all logic on rising edge
rrst  input  1  reset, synchronous, active-high
rinc  input  1  read request; honoured only when rempty=0
rurf_clr  input  1  clears the sticky underflow flag
rq2_wptr  input  address_width+1  write pointer, Gray, already synchronised into rclk
raddr  output  address_width  RAM read address, rbin[address_width-1:0]
rptr  output  address_width+1  Gray read pointer, to the write-domain synchroniser
rempty  output  1  FIFO empty, registered
raempty  output  1  almost empty, registered
rlevel  output  address_width+1  registered words available, 0..DEPTH
runderflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rrst=1 at rclk edge, overrides all other inputs):
  - rbin=0, rptr=0, raddr=0
  - rempty=1, raempty=1, rlevel=0, runderflow=0
- Pointer update:
  - rbin_next = rbin + (rinc & ~rempty), modulo 2**(address_width+1)
  - rgray_next = (rbin_next>>1) ^ rbin_next
  - rbin and rptr are registered every cycle from rbin_next and rgray_next
  - rptr changes by at most one bit per cycle
- Write-pointer decode: wbin_s = Gray-to-binary(rq2_wptr), combinational, using an XOR prefix from the MSB.
- Empty:
  - rempty <= (rgray_next == rq2_wptr)
  - Deasserts one rclk after rq2_wptr moves away from rptr.
  - A read that drains the last word asserts rempty on the same edge that advances rptr.
- Level:
  - rlevel <= wbin_s - rbin_next, modulo 2**(address_width+1)
  - Equals DEPTH when full and 0 when empty.
  - Consistent with rempty on every cycle: rlevel==0 exactly when rempty==1.
- Almost empty: raempty <= ((wbin_s - rbin_next) <= aempty_thresh); with aempty_thresh=0, raempty equals rempty.
- Underflow:
  - runderflow <= runderflow_set | (runderflow & ~rurf_clr), where runderflow_set = rinc & rempty.
  - Set has priority over clear in the same cycle.
  - An underflowing read does not move the pointer and does not change raddr.
- Wrap-around:
  - raddr wraps DEPTH-1 -> 0.
  - The pointer MSB toggles every DEPTH reads; rbin wraps 2*DEPTH-1 -> 0.
  - Level arithmetic stays correct across the wrap because both sides use the same modulus.
- Latency: every output is registered and valid one rclk after its cause. There is no combinational path from any input to any output.
- rq2_wptr is assumed Gray-coded and changing one bit per cycle. No checking is done on it.
- Reset asserted mid-stream: pointers return to 0 on the next edge regardless of rinc. After reset, the level follows whatever rq2_wptr presents, so both domains must reset together.

Test Plan:
- Reset: hold rrst 2 cycles with rinc=1 and rq2_wptr=5'b00110 -> rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
- Fill, then drain (address_width=4, aempty_thresh=2):
  - Step rq2_wptr through Gray codes 1..4 -> rlevel 1,2,3,4 one cycle after each step; rempty drops after the first step; raempty=1 until rlevel=3.
  - Then 4 reads -> raddr 0,1,2,3; rempty rises on the 4th read edge, with rlevel=0.
- Underflow: rinc=1 while rempty=1 -> runderflow=1 next cycle and raddr unchanged.
  - Assert rurf_clr and rinc together -> runderflow stays 1.
  - rurf_clr alone -> runderflow=0 next cycle.
- Full level: rq2_wptr = Gray(16) = 5'b11000 with rbin=0 -> rlevel=16, rempty=0, raempty=0.
- Wrap: 40 writes and reads interleaved -> raddr wraps 15->0 twice; rptr goes 5'b10000 -> 5'b00000 at rbin 31->0; rlevel never exceeds 16; rptr changes one bit per cycle.
- Mid-stream reset: at rbin=7, rlevel=3, assert rrst for 1 cycle -> next edge rptr=0, rempty=1, runderflow=0.

Source files
------------

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: async-FIFO read pointer, empty/almost-empty, fill level and sticky underflow
module rptr_empty_lvl #(
  parameter int address_width = 4,
  parameter int aempty_thresh = 2
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     rinc,
  input  logic                     rurf_clr,
  input  logic [address_width:0]   rq2_wptr,
  output logic [address_width-1:0] raddr,
  output logic [address_width:0]   rptr,
  output logic                     rempty,
  output logic                     raempty,
  output logic [address_width:0]   rlevel,
  output logic                     runderflow
);
  localparam logic [address_width:0] athr = (address_width+1)'(aempty_thresh);
  logic [address_width:0] rbin_q, rbin_d, rgray_q, rgray_d, wbin_s, rlevel_q, rlevel_d;
  logic rempty_q, rempty_d, raempty_q, raempty_d, runderflow_q, runderflow_d;
  for (genvar g = 0; g <= address_width; g++) begin : g_w2b
    assign wbin_s[g] = ^rq2_wptr[address_width:g];
  end
  always_comb begin
    rbin_d       = rbin_q + (address_width+1)'(rinc & ~rempty_q);
    rgray_d      = (rbin_d >> 1) ^ rbin_d;
    rempty_d     = rgray_d == rq2_wptr;
    rlevel_d     = wbin_s - rbin_d;
    raempty_d    = rlevel_d <= athr;
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~rurf_clr);
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
    end
  end
  assign raddr      = rbin_q[address_width-1:0];
  assign rptr       = rgray_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;
endmodule
